// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 8-bit combinational ALU: accepts accumulator-style
// instructions, drives registered operands, captures result/flags, returns a response.
module alu_cmd_sequencer #(
    parameter logic [7:0]  ACC_RST = 8'h00,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [1:0]       instr_mode,
    input  logic [7:0]       instr_imm,
    input  logic             instr_wb,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [7:0]       alu_out,
    input  logic             alu_sign,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_parity,
    input  logic             alu_overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic [4:0]       res_flags,
    output logic [7:0]       acc,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t           state, state_nxt;
    logic             wb_q, wb_nxt;
    logic [7:0]       a_nxt, b_nxt, acc_nxt, data_nxt;
    logic [2:0]       op_nxt;
    logic [4:0]       flags_nxt;
    logic             valid_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;

    // Ready depends only on state and reset, never on instr_valid.
    assign instr_ready = (state == IDLE) && rst_n;
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wb_q       <= 1'b0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_opcode <= 3'b000;
            acc        <= ACC_RST;
            res_data   <= 8'h00;
            res_flags  <= 5'b00000;
            res_valid  <= 1'b0;
            op_count   <= '0;
        end else begin
            state      <= state_nxt;
            wb_q       <= wb_nxt;
            alu_a      <= a_nxt;
            alu_b      <= b_nxt;
            alu_opcode <= op_nxt;
            acc        <= acc_nxt;
            res_data   <= data_nxt;
            res_flags  <= flags_nxt;
            res_valid  <= valid_nxt;
            op_count   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wb_nxt    = wb_q;
        a_nxt     = alu_a;
        b_nxt     = alu_b;
        op_nxt    = alu_opcode;
        acc_nxt   = acc;
        data_nxt  = res_data;
        flags_nxt = res_flags;
        valid_nxt = res_valid;
        cnt_nxt   = op_count;
        case (state)
            IDLE: begin
                if (accept) begin
                    wb_nxt = instr_wb;
                    case (instr_mode)
                        2'b00: begin
                            a_nxt     = acc;
                            b_nxt     = instr_imm;
                            op_nxt    = instr_op;
                            state_nxt = ISSUE;
                        end
                        2'b01: begin
                            a_nxt     = instr_imm;
                            b_nxt     = acc;
                            op_nxt    = instr_op;
                            state_nxt = ISSUE;
                        end
                        2'b11: begin
                            a_nxt     = acc;
                            b_nxt     = acc;
                            op_nxt    = instr_op;
                            state_nxt = ISSUE;
                        end
                        2'b10: begin
                            // Immediate load bypasses the ALU; flags keep their old value.
                            acc_nxt   = instr_imm;
                            data_nxt  = instr_imm;
                            valid_nxt = 1'b1;
                            state_nxt = RESP;
                        end
                    endcase
                end
            end
            ISSUE: state_nxt = CAPTURE;
            CAPTURE: begin
                flags_nxt = {alu_overflow, alu_parity, alu_carry, alu_zero, alu_sign};
                if (wb_q) begin
                    acc_nxt  = alu_out;
                    data_nxt = alu_out;
                end else begin
                    data_nxt = acc;
                end
                valid_nxt = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    valid_nxt = 1'b0;
                    if (op_count != {CNT_W{1'b1}}) begin
                        cnt_nxt = op_count + CNT_W'(1);
                    end
                    state_nxt = IDLE;
                end
            end
        endcase
    end

endmodule
